// File: rtl/writeback_arbiter.sv
// Register-file writeback stage: merges priority ALU results with a FIFO of memory results,
// keeping per-register write order. Optional stall statistics under `WB_STATS_EN`.
module writeback_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              Slow_Clock,
    input  logic              Reset,
    input  logic              ALU_Valid,
    input  logic [ADDR_W-1:0] ALU_Reg,
    input  logic [DATA_W-1:0] ALU_Data,
    output logic              Stall_ALU,
    input  logic              Mem_Valid,
    output logic              Mem_Ready,
    input  logic [ADDR_W-1:0] Mem_Reg,
    input  logic [DATA_W-1:0] Mem_Data,
    input  logic [ADDR_W-1:0] Query_Reg,
    output logic              Query_Pending,
    output logic              Reg_Write,
    output logic [ADDR_W-1:0] Reg_WR,
    output logic [DATA_W-1:0] Write_Data,
    output logic [15:0]       Stall_Count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]     fifo_reg_q  [FIFO_DEPTH];
    logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_valid_q, fifo_valid_d;
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;

    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] reg_wr_q, reg_wr_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    logic fifo_full, fifo_empty, waw_hit, query_hit;
    logic push, pop, take_alu, stall_alu;

    always_comb begin
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        waw_hit    = 1'b0;
        query_hit  = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_valid_q[i] && (fifo_reg_q[i] == ALU_Reg)) waw_hit = 1'b1;
            if (fifo_valid_q[i] && (fifo_reg_q[i] == Query_Reg)) query_hit = 1'b1;
        end
        // Register 0 is never a real destination
        if (ALU_Reg == '0) waw_hit = 1'b0;
        if (Query_Reg == '0) query_hit = 1'b0;
    end

    always_comb begin
        pop       = 1'b0;
        take_alu  = 1'b0;
        stall_alu = 1'b0;
        if (fifo_full) begin
            pop       = 1'b1;
            stall_alu = ALU_Valid;
        end else if (ALU_Valid && waw_hit) begin
            pop       = 1'b1;
            stall_alu = 1'b1;
        end else if (ALU_Valid) begin
            take_alu = 1'b1;
        end else if (!fifo_empty) begin
            pop = 1'b1;
        end
        if (Reset) stall_alu = 1'b0;
    end

    assign Mem_Ready     = !Reset && !fifo_full;
    assign Stall_ALU     = stall_alu;
    assign Query_Pending = query_hit;
    // Handshake to reg 0 completes but nothing is enqueued
    assign push          = Mem_Valid && Mem_Ready && (Mem_Reg != '0);

    always_comb begin
        fifo_valid_d = fifo_valid_q;
        if (pop)  fifo_valid_d[rd_ptr_q] = 1'b0;
        if (push) fifo_valid_d[wr_ptr_q] = 1'b1;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        reg_write_d  = 1'b0;
        reg_wr_d     = reg_wr_q;
        write_data_d = write_data_q;
        if (take_alu) begin
            if (ALU_Reg != '0) begin
                reg_write_d  = 1'b1;
                reg_wr_d     = ALU_Reg;
                write_data_d = ALU_Data;
            end
        end else if (pop) begin
            reg_write_d  = 1'b1;
            reg_wr_d     = fifo_reg_q[rd_ptr_q];
            write_data_d = fifo_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge Slow_Clock or posedge Reset) begin
        if (Reset) begin
            fifo_valid_q <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            reg_write_q  <= 1'b0;
            reg_wr_q     <= '0;
            write_data_q <= '0;
        end else begin
            fifo_valid_q <= fifo_valid_d;
            count_q      <= count_d;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            reg_write_q  <= reg_write_d;
            reg_wr_q     <= reg_wr_d;
            write_data_q <= write_data_d;
        end
    end

    // Payload storage needs no reset; validity is tracked separately
    always_ff @(posedge Slow_Clock) begin
        if (push) begin
            fifo_reg_q[wr_ptr_q]  <= Mem_Reg;
            fifo_data_q[wr_ptr_q] <= Mem_Data;
        end
    end

    assign Reg_Write  = reg_write_q;
    assign Reg_WR     = reg_wr_q;
    assign Write_Data = write_data_q;

`ifdef WB_STATS_EN
    logic [15:0] stall_count_q;

    always_ff @(posedge Slow_Clock or posedge Reset) begin
        if (Reset) begin
            stall_count_q <= '0;
        end else if (stall_alu && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign Stall_Count = stall_count_q;
`else
    assign Stall_Count = 16'h0000;
`endif

endmodule
